// File: rtl/snt_sram_pwr_ctrl.sv
// snt_sram_pwr_ctrl
// Power-sequencing initiator for one SRAM bank wrapper. Drives the bank's
// power-gate and retention controls, waits for the wrapper's registered gate
// acknowledge, and holds off bus requests while the bank is not fully powered.
//
// Handshake note: there is no valid/ready pair here. bus_req_i is passed to
// mem_req_o only in ON; in every other state it is reported back on stall_o
// and never reaches the wrapper. Power transitions are a request/acknowledge
// pair: pwrgate_no is the request level, pwrgate_ack_ni follows it
// (1 = gated, 0 = powered) and each wait is bounded by ACK_TIMEOUT cycles.
//
// dbg_state_o exposes the FSM state encoding for observation only.
module snt_sram_pwr_ctrl #(
    parameter int WAKEUP_CYCLES = 8,
    parameter int ACK_TIMEOUT   = 64,
    parameter int CNT_WIDTH     = $clog2(((WAKEUP_CYCLES > ACK_TIMEOUT) ?
                                           WAKEUP_CYCLES : ACK_TIMEOUT) + 1)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sleep_req_i,
    input  logic       retain_i,
    input  logic       bus_req_i,
    output logic       mem_req_o,
    output logic       stall_o,
    output logic       pwrgate_no,
    output logic       set_retentive_no,
    input  logic       pwrgate_ack_ni,
    output logic       powered_o,
    output logic       err_o,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        ST_ON        = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_RETAIN    = 3'd2,
        ST_GATE_WAIT = 3'd3,
        ST_OFF       = 3'd4,
        ST_WAKE_WAIT = 3'd5,
        ST_SETTLE    = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ACK_LAST  = CNT_WIDTH'(ACK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] WAKE_LAST = CNT_WIDTH'(WAKEUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_retain;
    logic                 r_pwrgate_n;
    logic                 r_set_ret_n;
    logic                 r_err;
    logic                 w_is_on;

    // Power sequencer: state, wait counter, latched retention choice and
    // registered wrapper controls all move together on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_ON;
            r_cnt       <= '0;
            r_retain    <= 1'b0;
            r_pwrgate_n <= 1'b1;
            r_set_ret_n <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_ON: begin
                    // An access issued in this cycle still goes out; the
                    // wrapper returns its data during DRAIN.
                    if (sleep_req_i) begin
                        r_retain <= retain_i;
                        r_cnt    <= '0;
                        r_state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_cnt <= '0;
                    if (r_retain) begin
                        r_set_ret_n <= 1'b0;
                        r_state     <= ST_RETAIN;
                    end else begin
                        r_pwrgate_n <= 1'b0;
                        r_state     <= ST_GATE_WAIT;
                    end
                end
                ST_RETAIN: begin
                    // Retention is asserted one cycle ahead of the gate.
                    r_cnt       <= '0;
                    r_pwrgate_n <= 1'b0;
                    r_state     <= ST_GATE_WAIT;
                end
                ST_GATE_WAIT: begin
                    if (pwrgate_ack_ni) begin
                        r_cnt   <= '0;
                        r_state <= ST_OFF;
                    end else if (r_cnt == ACK_LAST) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_OFF;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    r_set_ret_n <= ~r_retain;
                end
                ST_OFF: begin
                    if (!sleep_req_i) begin
                        r_pwrgate_n <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_WAKE_WAIT;
                    end
                end
                ST_WAKE_WAIT: begin
                    // Retention level is left as it was until ON is reached.
                    if (!pwrgate_ack_ni) begin
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end else if (r_cnt == ACK_LAST) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == WAKE_LAST) begin
                        r_set_ret_n <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_ON;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a powered bank.
                    r_cnt       <= '0;
                    r_pwrgate_n <= 1'b1;
                    r_set_ret_n <= 1'b1;
                    r_state     <= ST_ON;
                end
            endcase
        end
    end

    // Bus gating is combinational so a request in ON reaches the wrapper
    // in the same cycle.
    always_comb begin
        w_is_on   = (r_state == ST_ON);
        mem_req_o = w_is_on & bus_req_i;
        stall_o   = ~w_is_on & bus_req_i;
    end

    assign pwrgate_no       = r_pwrgate_n;
    assign set_retentive_no = r_set_ret_n;
    assign powered_o        = (r_state == ST_ON);
    assign err_o            = r_err;
    assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_snt_sram_pwr_ctrl.sv
// Directed testbench for snt_sram_pwr_ctrl with a registered wrapper model.
module tb_snt_sram_pwr_ctrl;

    localparam int WAKEUP_CYCLES = 8;
    localparam int ACK_TIMEOUT   = 64;

    // Hand-written state codes.
    localparam logic [2:0] S_ON   = 3'd0;
    localparam logic [2:0] S_DRN  = 3'd1;
    localparam logic [2:0] S_RET  = 3'd2;
    localparam logic [2:0] S_GW   = 3'd3;
    localparam logic [2:0] S_OFF  = 3'd4;
    localparam logic [2:0] S_WW   = 3'd5;
    localparam logic [2:0] S_SET  = 3'd6;

    logic       clk;
    logic       rst_n;
    logic       sleep_req;
    logic       retain;
    logic       bus_req;
    logic       mem_req;
    logic       stall;
    logic       pwrgate_n;
    logic       set_ret_n;
    logic       ack_n;
    logic       powered;
    logic       err;
    logic [2:0] dbg_state;

    logic       ack_stuck;

    int n_tests;
    int n_fail;

    logic [2:0] exp_q[$];

    snt_sram_pwr_ctrl #(
        .WAKEUP_CYCLES(WAKEUP_CYCLES),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .sleep_req_i     (sleep_req),
        .retain_i        (retain),
        .bus_req_i       (bus_req),
        .mem_req_o       (mem_req),
        .stall_o         (stall),
        .pwrgate_no      (pwrgate_n),
        .set_retentive_no(set_ret_n),
        .pwrgate_ack_ni  (ack_n),
        .powered_o       (powered),
        .err_o           (err),
        .dbg_state_o     (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wrapper model: acknowledge is pwrgate_no registered once, inverted
    // (1 = gated). ack_stuck holds it at "powered" to provoke a timeout.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ack_n <= 1'b0;
        else if (ack_stuck) ack_n <= 1'b0;
        else                ack_n <= ~pwrgate_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle 1ns past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int toggles;
    logic prev_pg;
    logic [2:0] exp_s;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        sleep_req = 1'b0;
        retain    = 1'b0;
        bus_req   = 1'b0;
        ack_stuck = 1'b0;

        // ---------------- reset ----------------
        #12;
        check("rst_pwrgate", pwrgate_n, 1);
        check("rst_setret",  set_ret_n, 1);
        check("rst_powered", powered, 1);
        check("rst_err",     err, 0);
        check("rst_state",   dbg_state, S_ON);
        step();
        rst_n = 1'b1;
        step();
        bus_req = 1'b1;
        #1;
        check("on_memreq", mem_req, 1);
        check("on_stall",  stall, 0);
        check("on_powered", powered, 1);
        check("on_err",    err, 0);

        // ---------------- retention sleep ----------------
        // Sleep and bus request together: access still goes out.
        sleep_req = 1'b1;
        retain    = 1'b1;
        #1;
        check("sim_memreq", mem_req, 1);
        step();                              // E0 sample edge
        retain = 1'b0;                       // latched value must hold
        check("e0_state",   dbg_state, S_DRN);
        check("e0_memreq",  mem_req, 0);
        check("e0_stall",   stall, 1);
        check("e0_pwrgate", pwrgate_n, 1);
        step();                              // E1
        check("e1_state",   dbg_state, S_RET);
        check("e1_setret",  set_ret_n, 0);
        check("e1_pwrgate", pwrgate_n, 1);
        step();                              // E2
        check("e2_state",   dbg_state, S_GW);
        check("e2_pwrgate", pwrgate_n, 0);
        check("e2_setret",  set_ret_n, 0);
        step();                              // E3
        check("e3_state",   dbg_state, S_GW);
        step();                              // E4
        check("e4_state",   dbg_state, S_OFF);
        check("off_setret", set_ret_n, 0);
        check("off_pwrgate", pwrgate_n, 0);
        check("off_powered", powered, 0);
        check("off_stall",  stall, 1);
        check("off_memreq", mem_req, 0);
        step_n(3);
        check("off_hold",   dbg_state, S_OFF);

        // ---------------- wake from retention ----------------
        sleep_req = 1'b0;
        step();                              // F0 sample edge
        check("f0_state",   dbg_state, S_WW);
        check("f0_pwrgate", pwrgate_n, 1);
        check("f0_setret",  set_ret_n, 0);
        step();                              // F1
        check("f1_state",   dbg_state, S_WW);
        step();                              // F2
        check("f2_state",   dbg_state, S_SET);
        step_n(7);                           // F9
        check("f9_powered", powered, 0);
        check("f9_setret",  set_ret_n, 0);
        step();                              // F10
        check("f10_powered", powered, 1);
        check("f10_setret",  set_ret_n, 1);
        check("f10_state",   dbg_state, S_ON);
        check("f10_memreq",  mem_req, 1);
        check("f10_err",     err, 0);

        // ---------------- gate acknowledge timeout ----------------
        bus_req   = 1'b0;
        ack_stuck = 1'b1;
        sleep_req = 1'b1;
        retain    = 1'b0;
        step();                              // E0
        check("to_e0_state", dbg_state, S_DRN);
        step();                              // E1: GATE_WAIT, cnt 0
        check("to_e1_state",  dbg_state, S_GW);
        check("to_e1_setret", set_ret_n, 1);
        check("to_e1_pwrgate", pwrgate_n, 0);
        step_n(63);                          // E64: last GATE_WAIT cycle
        check("to_e64_state", dbg_state, S_GW);
        check("to_e64_err",   err, 0);
        step();                              // E65
        check("to_e65_state", dbg_state, S_OFF);
        check("to_e65_err",   err, 1);
        check("to_off_setret", set_ret_n, 1);
        sleep_req = 1'b0;
        step();                              // WAKE_WAIT, ack already 0
        check("to_ww_state", dbg_state, S_WW);
        step();
        check("to_set_state", dbg_state, S_SET);
        step_n(8);
        check("to_on_state", dbg_state, S_ON);
        check("to_on_err",   err, 1);
        ack_stuck = 1'b0;

        // ---------------- one-cycle sleep pulse ----------------
        exp_q = '{S_DRN, S_GW, S_GW, S_OFF, S_WW, S_WW,
                  S_SET, S_SET, S_SET, S_SET, S_SET, S_SET, S_SET, S_SET, S_ON};
        toggles   = 0;
        prev_pg   = pwrgate_n;
        sleep_req = 1'b1;
        retain    = 1'b0;
        step();
        sleep_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) step();
            exp_s = exp_q.pop_front();
            check($sformatf("pulse_state_%0d", i), dbg_state, exp_s);
            if (pwrgate_n !== prev_pg) toggles++;
            prev_pg = pwrgate_n;
        end
        step_n(3);
        if (pwrgate_n !== prev_pg) toggles++;
        check("pulse_toggles", toggles, 2);
        check("pulse_end_on",  dbg_state, S_ON);
        check("pulse_err",     err, 1);

        // ---------------- reset during WAKE_WAIT ----------------
        sleep_req = 1'b1;
        retain    = 1'b1;
        step_n(5);
        check("rw_off", dbg_state, S_OFF);
        sleep_req = 1'b0;
        step();
        check("rw_ww",     dbg_state, S_WW);
        check("rw_setret", set_ret_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pwrgate", pwrgate_n, 1);
        check("ar_setret",  set_ret_n, 1);
        check("ar_powered", powered, 1);
        check("ar_err",     err, 0);
        check("ar_state",   dbg_state, S_ON);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snt_sram_pwr_ctrl.md
# snt_sram_pwr_ctrl

Power-sequencing initiator for one SRAM bank wrapper. It drives the bank's power-gate and retention controls, waits for the bank's registered gate acknowledge, and holds off bus requests while the bank is not fully powered. It sits between the bus-side memory port and the SRAM wrapper, and is driven by the always-on power manager.

## Interface

Parameters:
- WAKEUP_CYCLES, 8: settle cycles after power-up is acknowledged before access is re-enabled (≥1).
- ACK_TIMEOUT, 64: maximum cycles to wait for an acknowledge (≥2).
- CNT_WIDTH, $clog2(max(WAKEUP_CYCLES, ACK_TIMEOUT)+1): internal counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- sleep_req_i  in  1  level; 1 requests power-down, 0 requests power-up.
- retain_i  in  1  sampled on leaving ON; 1 selects retention, 0 selects full off.
- bus_req_i  in  1  bus request toward the bank.
- mem_req_o  out  1  gated request to the SRAM wrapper's req_i.
- stall_o  out  1  bus_req_i is being held off.
- pwrgate_no  out  1  to wrapper pwrgate_ni; 0 means gated.
- set_retentive_no  out  1  to wrapper set_retentive_ni; 0 means retention.
- pwrgate_ack_ni  in  1  from wrapper pwrgate_ack_no; 1 means gated acknowledged, 0 means powered acknowledged.
- powered_o  out  1  1 only in ON.
- err_o  out  1  sticky acknowledge-timeout flag.

## Operation

- States: ON, DRAIN, RETAIN, GATE_WAIT, OFF, WAKE_WAIT, SETTLE.
- ON: pwrgate_no=1, set_retentive_no=1. mem_req_o=bus_req_i, stall_o=0. If sleep_req_i=1, latch retain_i and go to DRAIN.
- DRAIN: one cycle. mem_req_o=0. Read data from an access issued in the last ON cycle is returned by the wrapper during this cycle. Next state is RETAIN if the latched retain bit is 1, otherwise GATE_WAIT.
- RETAIN: one cycle with set_retentive_no=0 and pwrgate_no still 1. Go to GATE_WAIT.
- GATE_WAIT: pwrgate_no=0. The counter increments from 0 each cycle.
  - pwrgate_ack_ni=1: go to OFF.
  - Counter reaches ACK_TIMEOUT-1 with no ack: set err_o and go to OFF.
- OFF: pwrgate_no=0. set_retentive_no=0 if retention was latched, else 1. If sleep_req_i=0, go to WAKE_WAIT.
- WAKE_WAIT: pwrgate_no=1, retention level unchanged. The counter runs from 0.
  - pwrgate_ack_ni=0: go to SETTLE.
  - Timeout at ACK_TIMEOUT-1: set err_o and go to SETTLE.
- SETTLE: counts WAKEUP_CYCLES cycles, then goes to ON. set_retentive_no returns to 1 on entry to ON.
- In every state other than ON: mem_req_o=0 and stall_o=bus_req_i.
- No abort. A sequence that has left ON completes to OFF before sleep_req_i is examined again. A sequence that has left OFF completes to ON before sleep_req_i is examined again.
- Simultaneous bus_req_i and sleep_req_i in ON: the access is issued (mem_req_o=1) and the FSM enters DRAIN on the next edge.
- The counter clears on every state entry.
- err_o stays set until reset.

## Timing

- Reset values: state ON, pwrgate_no=1, set_retentive_no=1, err_o=0, powered_o=1, mem_req_o=bus_req_i, stall_o=0, counter 0, latched retain bit 0.
- mem_req_o and stall_o are combinational from bus_req_i and state. All other outputs are registered or decoded from state only.
- With an ideal wrapper (ack registered one cycle after pwrgate_no), counting from the edge that samples sleep_req_i=1:
  - Retention power-down: pwrgate_no falls 3 edges later. OFF is reached 5 edges later.
  - Full power-down (no retention): pwrgate_no falls 2 edges later. OFF is reached 4 edges later.
- Power-up: pwrgate_no rises 1 edge after sleep_req_i=0 is sampled in OFF. ON is reached 2 + 1 + WAKEUP_CYCLES edges after that sample.
- Reset mid-sequence: all outputs return immediately to their reset values (asynchronous); pwrgate_no goes to 1.

## Test plan

- Reset, then bus_req_i=1 held → mem_req_o=1, stall_o=0, powered_o=1, err_o=0.
- Retention sleep (sleep_req_i=1, retain_i=1) with a responsive wrapper model:
  - set_retentive_no=0 one cycle before pwrgate_no=0.
  - OFF reached 5 edges after the sample, and bus_req_i=1 then gives stall_o=1, mem_req_o=0.
- Wake from retention with WAKEUP_CYCLES=8:
  - pwrgate_no=1 one edge after sleep_req_i=0.
  - powered_o=1 and set_retentive_no=1 exactly 11 edges after the sample.
- Ack held at 0 during GATE_WAIT with ACK_TIMEOUT=64 → OFF entered on the 64th GATE_WAIT cycle and err_o=1. err_o stays 1 through a full wake cycle.
- sleep_req_i pulsed for 1 cycle → full down sequence to OFF, then immediate wake back to ON. No state is skipped and pwrgate_no toggles exactly twice.
- rst_ni asserted during WAKE_WAIT → pwrgate_no=1, set_retentive_no=1, powered_o=1, err_o=0 without waiting for a clock edge.
